// File: rtl/auv_pkg.sv
// Shared types and master indices for the AUV Wishbone arbiter.
package auv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_t;

  localparam int ARB_M_DATA  = 0;
  localparam int ARB_M_FETCH = 1;

endpackage

// File: rtl/auv_wb_arbiter.sv
// Two-master arbiter for the core's single 16-bit pipelined Wishbone port.
// Optional no-response timeout enabled by defining AUV_WB_ARB_TIMEOUT_EN.
module auv_wb_arbiter
  import auv_pkg::*;
#(
  parameter int ADDR_WIDTH      = 24,
  parameter int PRIORITY_MODE   = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0][ADDR_WIDTH-1:0] m_wb_adr_i,
  input  logic [1:0][15:0]           m_wb_dat_i,
  input  logic [1:0][1:0]            m_wb_sel_i,
  input  logic [1:0]                 m_wb_we_i,
  input  logic [1:0]                 m_wb_stb_i,
  input  logic [1:0]                 m_wb_cyc_i,
  output logic [15:0]                m_wb_dat_o,
  output logic [1:0]                 m_wb_ack_o,
  output logic [1:0]                 m_wb_err_o,
  output logic [1:0]                 m_wb_stall_o,
  output logic [ADDR_WIDTH-1:0]      wb_adr_o,
  output logic [15:0]                wb_dat_o,
  output logic [1:0]                 wb_sel_o,
  output logic                       wb_we_o,
  output logic                       wb_stb_o,
  output logic                       wb_cyc_o,
  input  logic [15:0]                wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_stall_i,
  input  logic                       wb_err_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  arb_state_t    state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [OW-1:0] outstanding, outstanding_nxt;
  logic          granted, gsel, full, busy, resp, accept, release_cyc, timeout, pick;

  assign granted     = (state != ARB_IDLE);
  assign gsel        = (state == ARB_M1);
  assign full        = (outstanding == OUT_MAX);
  assign busy        = (outstanding != '0);
  assign resp        = (wb_ack_i | wb_err_i) & busy;
  assign release_cyc = granted & ~m_wb_cyc_i[gsel];
  assign accept      = wb_stb_o & ~wb_stall_i;
  assign m_wb_dat_o  = wb_dat_i;

`ifdef AUV_WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;

  // Fires on the TIMEOUT_CYCLES-th silent cycle after the oldest pending beat.
  assign timeout = busy & ~resp & (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !busy || resp || timeout || release_cyc) timer <= '0;
    else                                                   timer <= timer + TW'(1);
  end
`else
  // No timer in this build; the term only keeps the parameter referenced.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      last_grant  <= 1'b1;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      outstanding <= outstanding_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    pick           = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (m_wb_cyc_i[0] & m_wb_cyc_i[1]) begin
          pick           = (PRIORITY_MODE == 1) ? ~last_grant : 1'b0;
          state_nxt      = pick ? ARB_M1 : ARB_M0;
          last_grant_nxt = pick;
        end else if (m_wb_cyc_i[0]) begin
          state_nxt      = ARB_M0;
          last_grant_nxt = 1'b0;
        end else if (m_wb_cyc_i[1]) begin
          state_nxt      = ARB_M1;
          last_grant_nxt = 1'b1;
        end
      end
      default: begin
        if (timeout) begin
          state_nxt = ARB_IDLE;
        end else if (release_cyc) begin
          // Direct handover avoids an idle bubble when the other master is waiting.
          if (m_wb_cyc_i[~gsel]) begin
            state_nxt      = gsel ? ARB_M0 : ARB_M1;
            last_grant_nxt = ~gsel;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    outstanding_nxt = outstanding;
    if (!granted || release_cyc || timeout) outstanding_nxt = '0;
    else if (accept && !resp)               outstanding_nxt = outstanding + OW'(1);
    else if (!accept && resp)               outstanding_nxt = outstanding - OW'(1);
  end

  always_comb begin
    wb_adr_o     = '0;
    wb_dat_o     = '0;
    wb_sel_o     = '0;
    wb_we_o      = 1'b0;
    wb_stb_o     = 1'b0;
    wb_cyc_o     = 1'b0;
    m_wb_stall_o = 2'b11;
    m_wb_ack_o   = 2'b00;
    m_wb_err_o   = 2'b00;
    if (granted) begin
      wb_adr_o           = m_wb_adr_i[gsel];
      wb_dat_o           = m_wb_dat_i[gsel];
      wb_sel_o           = m_wb_sel_i[gsel];
      wb_we_o            = m_wb_we_i[gsel];
      wb_cyc_o           = m_wb_cyc_i[gsel] & ~timeout;
      wb_stb_o           = m_wb_stb_i[gsel] & m_wb_cyc_i[gsel] & ~full & ~timeout;
      m_wb_stall_o[gsel] = wb_stall_i | full;
      m_wb_ack_o[gsel]   = wb_ack_i & busy;
      m_wb_err_o[gsel]   = (wb_err_i & busy) | timeout;
    end
  end

endmodule
